// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer for the RV32I core.
// Turns the EX/MEM load/store into a req/gnt/rvalid bus transaction,
// builds byte enables and replicated store data, extends load data,
// stalls the pipeline until completion and reports faults/timeouts.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              stall_o,
    output logic              load_valid_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              fault_o,
    output logic              bus_err_o
);

    // Counter only ever needs to reach TIMEOUT_CYC-1 before the abort fires.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              err_q;
    logic              bad_access;
    logic              mem_op;
    logic              start;
    logic              timeout_hit;
    logic              capture;
    logic              set_err;
    logic [3:0]        be_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] ld_fmt;

    // Decode the incoming access: legality, byte enables, store-lane replication.
    always_comb begin
        bad_access = 1'b0;
        be_nxt     = 4'b1111;
        wdata_nxt  = wdata_i;
        case (funct3_i)
            3'b000, 3'b100: bad_access = 1'b0;
            3'b001, 3'b101: bad_access = addr_i[0];
            3'b010:         bad_access = (addr_i[1:0] != 2'b00);
            default:        bad_access = 1'b1;
        endcase
        // Unsigned widths only make sense for loads.
        if (is_store_i && funct3_i[2])
            bad_access = 1'b1;
        case (funct3_i[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << addr_i[1:0];
                wdata_nxt = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_nxt = {2{wdata_i[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = wdata_i;
            end
        endcase
    end

    // Select the addressed byte/half of the returned word and extend it.
    always_comb begin
        rd_shift = bus_rdata_i >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld_fmt = {24'b0, rd_shift[7:0]};
            3'b001:  ld_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  ld_fmt = {16'b0, rd_shift[15:0]};
            default: ld_fmt = bus_rdata_i;
        endcase
    end

    // Next-state logic and status outputs; timeout wins over a same-cycle gnt/rvalid.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        set_err     = 1'b0;
        mem_op      = req_valid_i & (is_load_i | is_store_i);
        start       = (state == IDLE) & mem_op & ~bad_access;
        fault_o     = (state == IDLE) & mem_op & bad_access;
        timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ: begin
                if (timeout_hit) begin
                    state_nxt = DONE;
                    set_err   = 1'b1;
                end else if (bus_gnt_i) begin
                    state_nxt = bus_we_o ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (timeout_hit) begin
                    state_nxt = DONE;
                    set_err   = 1'b1;
                end else if (bus_rvalid_i) begin
                    state_nxt = DONE;
                    capture   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        bus_req_o    = (state == REQ);
        stall_o      = start | (state == REQ) | (state == WAIT);
        load_valid_o = (state == DONE) & ~bus_we_o & ~err_q;
        bus_err_o    = (state == DONE) & err_q;
    end

    // State, latched request fields, timeout counter and load result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            err_q       <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            load_data_o <= '0;
        end else begin
            state <= state_nxt;
            err_q <= set_err;
            if (start) begin
                bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                bus_be_o    <= be_nxt;
                bus_wdata_o <= wdata_nxt;
                bus_we_o    <= is_store_i;
                f3_q        <= funct3_i;
                off_q       <= addr_i[1:0];
                cnt         <= '0;
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (capture)
                load_data_o <= ld_fmt;
            else if (set_err)
                load_data_o <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// accesses, all checked against an arithmetic model of the access rules.
module tb_mem_access_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic        stall, load_valid, fault, bus_err;
    logic [31:0] load_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ld = '0;

    mem_access_ctrl #(.TIMEOUT_CYC(TO), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .is_load_i(is_load), .is_store_i(is_store),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
        .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
        .stall_o(stall), .load_valid_o(load_valid), .load_data_o(load_data),
        .fault_o(fault), .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_fault(bit st, logic [2:0] f3, logic [31:0] a);
        int sz;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (st && f3 >= 3'd4) return 1'b1;
        sz = 1 << f3[1:0];
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
        int sz = 1 << f3[1:0];
        return 4'(((1 << sz) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] wd);
        int sz = 1 << f3[1:0];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
        int sz = 1 << f3[1:0];
        longint v;
        if (sz == 4) return rd;
        v = longint'(rd) >> (8 * int'(a[1:0]));
        v = v & ((longint'(1) << (8 * sz)) - 1);
        if (!f3[2] && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    // ---------------- scenario driver ----------------
    // Called at a falling edge with the DUT idle; drives one access, acts as
    // the bus (gnt after gdly extra REQ cycles, rvalid in WAIT cycle rdly) and
    // returns in the IDLE cycle after DONE so a following call is back-to-back.
    task automatic do_access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int gdly, input int rdly);
        bit st = !ld;
        bit flt = m_fault(st, f3, a);
        int need = (gdly + 1) + (ld ? rdly : 0);
        bit tmo = !flt && (need >= TO);
        int exp_st = tmo ? (1 + TO) : (1 + need);
        int stalls = 1, reqc = 0, waitc = 0;
        bit granted = 0, done = 0, lv = 0, er = 0;
        logic [31:0] ldat = '0;
        logic [68:0] exp_bus = {a & 32'hFFFF_FFFC, m_be(f3, a), m_wdata(f3, wd), st};
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        checks++;
        if (fault !== flt) begin
            errors++; $display("FAIL fault_o f3=%0d addr=%h got %b exp %b", f3, a, fault, flt);
        end
        checks++;
        if (stall !== !flt || bus_req !== 1'b0) begin
            errors++; $display("FAIL start_stall got stall=%b req=%b exp stall=%b req=0", stall, bus_req, !flt);
        end
        if (flt) begin
            @(negedge clk); #1;
            checks++;
            if (bus_req !== 1'b0 || stall !== 1'b0) begin
                errors++; $display("FAIL fault_idle got req=%b stall=%b exp 0 0", bus_req, stall);
            end
            req_valid = 1'b0;
            return;
        end
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
            #1;
            if (stall) stalls++;
            if (bus_req) begin
                checks++;
                if ({bus_addr, bus_be, bus_wdata, bus_we} !== exp_bus) begin
                    errors++;
                    $display("FAIL bus_fields got addr=%h be=%b wd=%h we=%b exp addr=%h be=%b wd=%h we=%b",
                             bus_addr, bus_be, bus_wdata, bus_we,
                             exp_bus[68:37], exp_bus[36:33], exp_bus[32:1], exp_bus[0]);
                end
                reqc++;
                if (reqc > gdly) begin bus_gnt = 1'b1; granted = 1; end
            end else if (granted && ld) begin
                waitc++;
                if (waitc == rdly) begin bus_rvalid = 1'b1; bus_rdata = rd; end
            end
            if (!stall) begin
                done = 1; lv = load_valid; er = bus_err; ldat = load_data;
            end
        end
        if (tmo) model_ld = '0;
        else if (ld) model_ld = m_load(f3, a, rd);
        checks++;
        if (!done) begin
            errors++; $display("FAIL done_timeout access never completed");
        end
        checks++;
        if (stalls !== exp_st) begin
            errors++; $display("FAIL stall_cycles got %0d exp %0d", stalls, exp_st);
        end
        checks++;
        if (lv !== (ld && !tmo) || er !== tmo) begin
            errors++; $display("FAIL done_flags got lv=%b err=%b exp lv=%b err=%b", lv, er, ld && !tmo, tmo);
        end
        checks++;
        if (ldat !== model_ld) begin
            errors++; $display("FAIL load_data got %h exp %h", ldat, model_ld);
        end
        @(negedge clk); #1;
        checks++;
        if (load_valid !== 1'b0 || bus_err !== 1'b0 || load_data !== model_ld) begin
            errors++; $display("FAIL after_done got lv=%b err=%b data=%h exp 0 0 %h",
                               load_valid, bus_err, load_data, model_ld);
        end
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({bus_req, bus_we, stall, load_valid, bus_err, fault} !== 6'b0 ||
            bus_addr !== '0 || bus_be !== '0 || bus_wdata !== '0 || load_data !== '0) begin
            errors++;
            $display("FAIL %s got req=%b we=%b stall=%b lv=%b err=%b flt=%b addr=%h be=%b wd=%h ld=%h exp all 0",
                     tag, bus_req, bus_we, stall, load_valid, bus_err, fault,
                     bus_addr, bus_be, bus_wdata, load_data);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = '0; addr = '0; wdata = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        model_ld = '0;
        @(negedge clk);
    endtask

    task automatic test_store_byte();
        do_access(0, 3'b000, 32'h0000_1003, 32'h0000_00A5, '0, 0, 0);
    endtask

    task automatic test_load_byte();
        do_access(1, 3'b000, 32'h0000_2002, 32'h0, 32'h0080_0000, 3, 2);
        do_access(1, 3'b100, 32'h0000_2002, 32'h0, 32'h0080_0000, 3, 2);
        checks++;
        if (model_ld !== 32'h0000_0080 || load_data !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu_value got %h exp 00000080", load_data);
        end
    endtask

    task automatic test_fault();
        do_access(1, 3'b010, 32'h0000_3002, '0, '0, 0, 1);
        do_access(1, 3'b011, 32'h0000_3000, '0, '0, 0, 1);
        do_access(0, 3'b101, 32'h0000_3000, '0, '0, 0, 1);
        do_access(0, 3'b001, 32'h0000_3001, '0, '0, 0, 1);
    endtask

    task automatic test_timeout();
        do_access(1, 3'b001, 32'h0000_4000, '0, '0, 1000, 1);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
        funct3 = 3'b010; addr = 32'h0000_6000; wdata = 32'h1234_5678;
        @(negedge clk); #1;
        bus_gnt = 1'b1;
        @(negedge clk); #1;
        bus_gnt = 1'b0; req_valid = 1'b0; is_load = 1'b0;
        checks++;
        if (stall !== 1'b1 || bus_req !== 1'b0) begin
            errors++; $display("FAIL wait_state got stall=%b req=%b exp 1 0", stall, bus_req);
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("reset_mid");
        rst_n = 1'b1;
        @(negedge clk); #1;
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        bus_rvalid = 1'b0;
        check_reset_outputs("stale_rvalid");
        @(negedge clk); #1;
        check_reset_outputs("stale_rvalid2");
        model_ld = '0;
    endtask

    task automatic test_back_to_back();
        do_access(0, 3'b010, 32'h0000_5000, 32'hCAFE_F00D, '0, 0, 0);
        do_access(1, 3'b101, 32'h0000_5002, '0, 32'hBEEF_0000, 0, 1);
        checks++;
        if (load_data !== 32'h0000_BEEF) begin
            errors++; $display("FAIL lhu_value got %h exp 0000BEEF", load_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_store_byte();
        test_load_byte();
        test_fault();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
